// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: transfer sequencer for the SPI master.
// Accepts a character-transfer command, starts spi_clgen, shifts tx bits out
// and samples rx bits on the edge strobes it returns, then pulses done.
module spi_xfer_ctrl #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 5
) (
    input  logic               wb_clk,
    input  logic               wb_reset_n,
    input  logic               start,
    input  logic [LEN_W-1:0]   char_len,
    input  logic [MAX_LEN-1:0] tx_data,
    input  logic               lsb_first,
    input  logic               tx_negedge,
    input  logic               rx_negedge,
    input  logic               pos_edge,
    input  logic               neg_edge,
    input  logic               miso,
    output logic               go,
    output logic               tip,
    output logic               lstclk,
    output logic               mosi,
    output logic               busy,
    output logic               done,
    output logic [MAX_LEN-1:0] rx_data
);

    // One extra bit so that a full MAX_LEN character fits in the counter.
    localparam int CNT_W = LEN_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        XFER,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   start_len;
    logic [CNT_W-1:0]   cnt_after;
    logic [MAX_LEN-1:0] tx_sr;
    logic [MAX_LEN-1:0] rx_sr;
    logic [MAX_LEN-1:0] tx_aligned;
    logic [MAX_LEN-1:0] rx_shifted;
    logic               lsb_q;
    logic               tx_neg_q;
    logic               rx_neg_q;
    logic               accept;
    logic               rx_edge;
    logic               tx_edge;

    // Command decode, edge selection and the next rx shift-register value.
    always_comb begin
        accept     = (state == IDLE) && start;
        start_len  = (char_len == '0) ? CNT_W'(MAX_LEN) : {1'b0, char_len};
        // msb-first data is left-aligned so its first bit sits at the top.
        tx_aligned = tx_data << (CNT_W'(MAX_LEN) - start_len);
        rx_edge    = (state == XFER) && (rx_neg_q ? neg_edge : pos_edge);
        tx_edge    = (state == XFER) && (tx_neg_q ? neg_edge : pos_edge);
        // A same-cycle sample is accounted for before deciding whether to shift.
        cnt_after  = (rx_edge && (bit_cnt != '0)) ? (bit_cnt - CNT_W'(1)) : bit_cnt;
        if (lsb_q) begin
            rx_shifted = (rx_sr >> 1) | (MAX_LEN'(miso) << (len_q - CNT_W'(1)));
        end else begin
            rx_shifted = {rx_sr[MAX_LEN-2:0], miso};
        end
    end

    // State register.
    always_ff @(posedge wb_clk or negedge wb_reset_n) begin
        if (!wb_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the state-decoded handshake outputs.
    always_comb begin
        state_next = state;
        go         = 1'b0;
        tip        = 1'b0;
        lstclk     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                go         = 1'b1;
                tip        = 1'b1;
                lstclk     = (bit_cnt == CNT_W'(1));
                state_next = XFER;
            end
            XFER: begin
                tip    = 1'b1;
                lstclk = (bit_cnt == CNT_W'(1));
                if (rx_edge && (bit_cnt == CNT_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: command latch, tx/rx shift registers, bit counter and result.
    always_ff @(posedge wb_clk or negedge wb_reset_n) begin
        if (!wb_reset_n) begin
            bit_cnt  <= '0;
            len_q    <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            mosi     <= 1'b0;
            lsb_q    <= 1'b0;
            tx_neg_q <= 1'b0;
            rx_neg_q <= 1'b0;
        end else begin
            if (accept) begin
                bit_cnt  <= start_len;
                len_q    <= start_len;
                lsb_q    <= lsb_first;
                tx_neg_q <= tx_negedge;
                rx_neg_q <= rx_negedge;
                rx_sr    <= '0;
                if (lsb_first) begin
                    mosi  <= tx_data[0];
                    tx_sr <= tx_data >> 1;
                end else begin
                    mosi  <= tx_aligned[MAX_LEN-1];
                    tx_sr <= tx_aligned << 1;
                end
            end
            if (rx_edge) begin
                rx_sr   <= rx_shifted;
                bit_cnt <= cnt_after;
                if (bit_cnt == CNT_W'(1)) begin
                    rx_data <= rx_shifted;
                end
            end
            if (tx_edge && (cnt_after != '0)) begin
                mosi  <= lsb_q ? tx_sr[0] : tx_sr[MAX_LEN-1];
                tx_sr <= lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: drives spi_xfer_ctrl with directed and random transfers,
// plays the role of spi_clgen and the slave, and compares against a
// bit-list model of what should appear on mosi and land in rx_data.
module tb_spi_xfer_ctrl;

    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 5;

    logic               wb_clk     = 1'b0;
    logic               wb_reset_n = 1'b0;
    logic               start      = 1'b0;
    logic [LEN_W-1:0]   char_len   = '0;
    logic [MAX_LEN-1:0] tx_data    = '0;
    logic               lsb_first  = 1'b0;
    logic               tx_negedge = 1'b0;
    logic               rx_negedge = 1'b0;
    logic               pos_edge   = 1'b0;
    logic               neg_edge   = 1'b0;
    logic               miso       = 1'b0;
    logic               go;
    logic               tip;
    logic               lstclk;
    logic               mosi;
    logic               busy;
    logic               done;
    logic [MAX_LEN-1:0] rx_data;

    int                 checks = 0;
    int                 errors = 0;
    logic               last_mosi = 1'b0;
    logic [MAX_LEN-1:0] last_rx   = '0;

    spi_xfer_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .wb_clk     (wb_clk),
        .wb_reset_n (wb_reset_n),
        .start      (start),
        .char_len   (char_len),
        .tx_data    (tx_data),
        .lsb_first  (lsb_first),
        .tx_negedge (tx_negedge),
        .rx_negedge (rx_negedge),
        .pos_edge   (pos_edge),
        .neg_edge   (neg_edge),
        .miso       (miso),
        .go         (go),
        .tip        (tip),
        .lstclk     (lstclk),
        .mosi       (mosi),
        .busy       (busy),
        .done       (done),
        .rx_data    (rx_data)
    );

    // Free-running system clock.
    always #5 wb_clk = ~wb_clk;

    // Watchdog so the run always ends even if the bench logic gets stuck.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_go"}, go, 0);
        checkOutput({tag, "_tip"}, tip, 0);
        checkOutput({tag, "_lstclk"}, lstclk, 0);
        checkOutput({tag, "_mosi"}, mosi, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_rx"}, rx_data, 0);
    endtask

    // Idle cycles inside XFER, sometimes with a start pulse that must be ignored.
    task automatic gapCycles(input bit extras);
        if (extras) begin
            repeat ($urandom_range(0, 2)) begin
                if ($urandom_range(0, 3) == 0) begin
                    start    = 1'b1;
                    char_len = LEN_W'($urandom);
                    tx_data  = $urandom;
                end
                @(negedge wb_clk);
                start = 1'b0;
            end
        end
    endtask

    // One transfer. miso_mode: 0 loopback, 1 tied 0, 2 tied 1, 3 random.
    // abort_at >= 0 pulls reset just before that bit's sample edge.
    task automatic applyStimulus(input int len_code, input logic [31:0] data, input logic lsb,
                                 input logic txn, input logic rxn, input int miso_mode,
                                 input int abort_at, input bit extras);
        int          n;
        logic [31:0] exp_rx;
        logic        tx_bit;
        logic        rx_bit;
        bit          both;
        n      = (len_code == 0) ? MAX_LEN : len_code;
        exp_rx = '0;

        char_len   = LEN_W'(len_code);
        tx_data    = data;
        lsb_first  = lsb;
        tx_negedge = txn;
        rx_negedge = rxn;
        start      = 1'b1;
        @(negedge wb_clk);
        start      = 1'b0;
        char_len   = LEN_W'($urandom);
        tx_data    = $urandom;
        lsb_first  = 1'($urandom);
        tx_negedge = 1'($urandom);
        rx_negedge = 1'($urandom);

        checkOutput("load_go", go, 1);
        checkOutput("load_busy", busy, 1);
        checkOutput("load_tip", tip, 1);
        checkOutput("load_done", done, 0);
        checkOutput("load_lstclk", lstclk, (n == 1) ? 1 : 0);
        checkOutput("load_mosi", mosi, lsb ? data[0] : data[n-1]);
        @(negedge wb_clk);
        checkOutput("xfer_go", go, 0);
        checkOutput("xfer_busy", busy, 1);

        for (int k = 0; k < n; k++) begin
            tx_bit = lsb ? data[k] : data[n-1-k];
            gapCycles(extras);
            if (k == abort_at) begin
                #2;
                wb_reset_n = 1'b0;
                #1;
                checkAllZero("abort");
                @(negedge wb_clk);
                wb_reset_n = 1'b1;
                last_mosi  = 1'b0;
                last_rx    = '0;
                return;
            end
            checkOutput("mosi_bit", mosi, tx_bit);
            checkOutput("lstclk_bit", lstclk, (k == n - 1) ? 1 : 0);
            checkOutput("tip_bit", tip, 1);
            case (miso_mode)
                0:       rx_bit = tx_bit;
                1:       rx_bit = 1'b0;
                2:       rx_bit = 1'b1;
                default: rx_bit = 1'($urandom);
            endcase
            miso = rx_bit;
            if (lsb) begin
                exp_rx[k] = rx_bit;
            end else begin
                exp_rx[n-1-k] = rx_bit;
            end
            both = extras && (txn != rxn) && ($urandom_range(0, 3) == 0);
            if (rxn) neg_edge = 1'b1; else pos_edge = 1'b1;
            if (both) begin
                if (txn) neg_edge = 1'b1; else pos_edge = 1'b1;
            end
            @(negedge wb_clk);
            pos_edge = 1'b0;
            neg_edge = 1'b0;
            miso     = 1'($urandom);
            if (k == n - 1) break;
            if ((txn != rxn) && !both) begin
                gapCycles(extras);
                if (txn) neg_edge = 1'b1; else pos_edge = 1'b1;
                @(negedge wb_clk);
                pos_edge = 1'b0;
                neg_edge = 1'b0;
            end
        end

        checkOutput("done_pulse", done, 1);
        checkOutput("done_rx", rx_data, exp_rx);
        checkOutput("done_tip", tip, 0);
        checkOutput("done_lstclk", lstclk, 0);
        checkOutput("done_busy", busy, 1);
        checkOutput("done_go", go, 0);
        if (extras && ($urandom_range(0, 1) == 1)) begin
            start = 1'b1;
        end
        @(negedge wb_clk);
        start = 1'b0;
        checkOutput("post_done", done, 0);
        checkOutput("post_busy", busy, 0);
        checkOutput("post_rx_hold", rx_data, exp_rx);
        checkOutput("post_mosi_hold", mosi, lsb ? data[n-1] : data[0]);
        last_mosi = lsb ? data[n-1] : data[0];
        last_rx   = exp_rx;
    endtask

    // Stray clock-generator strobes while idle must leave everything alone.
    task automatic strayEdges();
        pos_edge = 1'b1;
        @(negedge wb_clk);
        pos_edge = 1'b0;
        neg_edge = 1'b1;
        @(negedge wb_clk);
        neg_edge = 1'b0;
        pos_edge = 1'b1;
        neg_edge = 1'b1;
        @(negedge wb_clk);
        pos_edge = 1'b0;
        neg_edge = 1'b0;
        checkOutput("stray_busy", busy, 0);
        checkOutput("stray_done", done, 0);
        checkOutput("stray_mosi", mosi, last_mosi);
        checkOutput("stray_rx", rx_data, last_rx);
    endtask

    // Main sequence: reset, directed transfers, reset abort, random transfers.
    initial begin
        #12;
        checkAllZero("reset");
        @(negedge wb_clk);
        wb_reset_n = 1'b1;
        @(negedge wb_clk);

        applyStimulus(8, 32'h0000_00A5, 1'b0, 1'b1, 1'b0, 0, -1, 1'b0);
        applyStimulus(0, 32'h8000_0001, 1'b1, 1'b1, 1'b0, 0, -1, 1'b0);
        applyStimulus(1, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1, -1, 1'b0);
        applyStimulus(4, 32'h0000_000C, 1'b0, 1'b0, 1'b0, 2, -1, 1'b0);
        strayEdges();

        applyStimulus(16, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 0, 5, 1'b0);
        strayEdges();
        applyStimulus(12, 32'h0000_0ABC, 1'b1, 1'b0, 1'b1, 3, -1, 1'b1);

        for (int t = 0; t < 40; t++) begin
            int lc;
            int ab;
            lc = $urandom_range(0, 31);
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, (lc == 0) ? 31 : lc - 1) : -1;
            applyStimulus(lc, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                          $urandom_range(0, 3), ab, 1'b1);
            if ($urandom_range(0, 4) == 0) begin
                strayEdges();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
Transfer sequencer for the SPI master. It sits between the register/Wishbone slave logic and spi_clgen. It accepts a character-transfer command and starts the clock generator. It then shifts tx data out and samples rx data on the edge strobes that spi_clgen returns. It flags the last clock so the generator can stop, and reports completion with a one-cycle done pulse.

Parameters:
MAX_LEN, 32, maximum character length in bits; also the width of the tx and rx data paths.
LEN_W, 5, width of char_len. A char_len value of 0 encodes MAX_LEN.

Ports:
wb_clk  input  1  system clock; all logic is on its rising edge.
wb_reset_n  input  1  asynchronous, active-low reset.
start  input  1  one-cycle command strobe; accepted only in IDLE.
char_len  input  LEN_W  bits to transfer (0 = MAX_LEN); sampled at an accepted start.
tx_data  input  MAX_LEN  transmit word; sampled at an accepted start.
lsb_first  input  1  1 = shift bit 0 first; sampled at start.
tx_negedge  input  1  1 = drive mosi on the falling sclk edge, 0 = on the rising edge; sampled at start.
rx_negedge  input  1  1 = sample miso on the falling sclk edge, 0 = on the rising edge; sampled at start.
pos_edge  input  1  rising-edge strobe from spi_clgen (cpol_0).
neg_edge  input  1  falling-edge strobe from spi_clgen (cpol_1).
miso  input  1  serial data in.
go  output  1  one-cycle start pulse to spi_clgen.
tip  output  1  transfer in progress, to spi_clgen.
lstclk  output  1  last-clock indication to spi_clgen.
mosi  output  1  serial data out.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle completion pulse.
rx_data  output  MAX_LEN  received word; holds its value until the next completion.

Behaviour:
- Reset (asynchronous, wb_reset_n=0): state IDLE; go, tip, lstclk, mosi, busy and done are 0; rx_data=0; shift and bit counters are 0.
- States:
  - IDLE: on start, latch the command fields and load the bit counter with N (char_len, with 0 mapped to MAX_LEN). Go to LOAD. start in any other state is ignored; no queuing.
  - LOAD: one cycle. Assert go=1. Drive mosi with the first bit (tx[N-1] for msb-first, tx[0] for lsb-first). Set tip=1. Go to XFER.
  - XFER: tip=1.
    - tx edge (neg_edge if tx_negedge, else pos_edge): shift out the next bit, but only if at least one bit remains to be sampled after the current one.
    - rx edge: shift miso into the rx shift register (msb-first fills from bit 0 upward and shifts left; lsb-first fills bit N-1 downward) and decrement the bit counter.
    - lstclk=1 while the bit counter equals 1.
    - When an rx edge decrements the counter from 1 to 0, go to DONE.
  - DONE: one cycle. tip=0, lstclk=0, done=1. rx_data receives the rx shift register, right-aligned for msb-first and with unused upper bits 0 for N<MAX_LEN. Go to IDLE.
- Simultaneous pos_edge and neg_edge in one cycle is illegal from spi_clgen. If it happens, rx takes priority and tx is processed in the same cycle.
- When tx edge equals rx edge (both flags equal), the sample happens before the shift in the same cycle.
- Edge strobes in IDLE or DONE are ignored.
- mosi holds its last driven bit after the transfer, until the next LOAD.
- Latency: done asserts exactly 1 cycle after the rx edge of the final bit. busy rises 1 cycle after an accepted start.
- Counter width is LEN_W+1 so MAX_LEN fits. No wrap: the counter never decrements below 0.
- Reset asserted mid-transfer aborts immediately to the reset values. No done pulse is produced and rx_data is cleared.

Test Plan:
- Reset in every state: assert wb_reset_n=0 mid-XFER -> all outputs 0 within the same cycle; a later start proceeds normally.
- msb-first, N=8, tx_data=0xA5, tx_negedge=1, rx_negedge=0, miso looped to mosi -> mosi sequence 1,0,1,0,0,1,0,1; rx_data=0x000000A5; done after 8th pos_edge +1 cycle; go high in exactly 1 cycle.
- lsb-first, char_len=0 (32 bits), tx_data=0x80000001, loopback -> first mosi bit 1; rx_data=0x80000001; lstclk high only during bit 32.
- N=1, tx_data=1, miso tied 0 -> lstclk high from LOAD through the single rx edge; rx_data=0; done one cycle later.
- start pulses during XFER and during DONE -> ignored; stray pos_edge/neg_edge in IDLE -> no state change, mosi unchanged.
- tx_negedge=rx_negedge=0, N=4, tx_data=0xC, miso=1 constant -> rx_data=0xF; mosi 1,1,0,0, each updating after its sample.
